// File: rtl/addsub_seq_ctrl.sv
// Wide add/subtract sequencer: one 4-bit add/sub slice stepped across NIBBLES nibbles, LSB first.
// Optional `ADDSUB_ZERO_FLAG_EN` adds a registered zero flag that updates with result.
module addsub_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cOut,
  output logic                   ovf
`ifdef ADDSUB_ZERO_FLAG_EN
  ,
  output logic                   zero
`endif
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              carry;
  logic [W-1:0]      aLat;
  logic [W-1:0]      bLat;
  logic [W-1:0]      shadow;
  logic [4:0]        sum;
  logic [W-1:0]      resultNext;

  function automatic logic [4:0] nibbleAdd(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    nibbleAdd = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
  endfunction

  // Operand latches shift right each step, so the active nibble is always [3:0];
  // bLat already holds b XOR sub, carry starts at sub.
  assign sum        = nibbleAdd(aLat[3:0], bLat[3:0], carry);
  assign resultNext = {sum[3:0], shadow[W-1:4]};

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      aLat   <= '0;
      bLat   <= '0;
      shadow <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cOut   <= 1'b0;
      ovf    <= 1'b0;
`ifdef ADDSUB_ZERO_FLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            aLat  <= a;
            bLat  <= b ^ {W{sub}};
            carry <= sub;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          aLat   <= aLat >> 4;
          bLat   <= bLat >> 4;
          shadow <= resultNext;
          carry  <= sum[4];
          idx    <= idx + 1'b1;
          // Last nibble: the MSB nibbles of the operands sit in [3:0] right now.
          if (idx == IDX_W'(NIBBLES - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= resultNext;
            cOut   <= sum[4];
            ovf    <= (aLat[3] == bLat[3]) && (sum[3] != aLat[3]);
`ifdef ADDSUB_ZERO_FLAG_EN
            zero   <= (resultNext == '0);
`endif
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Self-checking bench for addsub_seq_ctrl (NIBBLES=4): directed plan vectors, random
// operations against an integer-arithmetic model, handshake and mid-operation reset.
module tb_addsub_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rstN;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cOut;
  logic         ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int nChecks = 0;
  int nFails  = 0;

  addsub_seq_ctrl #(.NIBBLES(NIB)) dut (
    .clk    (clk),
    .rstN   (rstN),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cOut   (cOut),
    .ovf    (ovf)
`ifdef ADDSUB_ZERO_FLAG_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                       output logic [W-1:0] r, output logic c, output logic o);
    longint ua, ub, full;
    longint sa, sb, exact;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    if (!ms) begin
      full  = ua + ub;
      c     = (full >= 65536);
      exact = sa + sb;
    end else begin
      full  = ua - ub;
      c     = (ua >= ub);
      exact = sa - sb;
    end
    r = W'(full);
    o = (exact > 32767) || (exact < -32768);
  endtask

  // Drives one operation and collects what the DUT shows; it makes no judgement itself.
  task automatic runOp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                       input bit now, output int busyCyc, output int doneCyc,
                       output bit sawDone, output logic [W-1:0] r, output logic c,
                       output logic o, output logic z);
    int cyc;
    if (!now) @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    busyCyc = 0; doneCyc = 0; sawDone = 1'b0;
    r = 'x; c = 1'bx; o = 1'bx; z = 1'bx;
    cyc = 1;
    while (cyc <= 20 && !sawDone) begin
      if (done) begin
        sawDone = 1'b1;
        doneCyc = cyc;
        r = result; c = cOut; o = ovf;
`ifdef ADDSUB_ZERO_FLAG_EN
        z = zero;
`else
        z = 1'b0;
`endif
      end else begin
        if (busy) busyCyc++;
        cyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #3 rstN = 1'b0;
    repeat (3) @(negedge clk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL reset_busy got=%b want=0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL reset_done got=%b want=0", done); end
    nChecks++; if (result !== '0) begin nFails++; $display("FAIL reset_result got=%h want=0", result); end
    nChecks++; if (cOut !== 1'b0) begin nFails++; $display("FAIL reset_cOut got=%b want=0", cOut); end
    nChecks++; if (ovf !== 1'b0) begin nFails++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`ifdef ADDSUB_ZERO_FLAG_EN
    nChecks++; if (zero !== 1'b0) begin nFails++; $display("FAIL reset_zero got=%b want=0", zero); end
`endif
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [5] = '{16'h1234, 16'h0005, 16'h0007, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] vb [5] = '{16'h0FFF, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
    logic         vs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int bc, dc; bit sd;
    logic [W-1:0] r, er; logic c, o, z, ec, eo;
    for (int i = 0; i < 5; i++) begin
      model(va[i], vb[i], vs[i], er, ec, eo);
      runOp(va[i], vb[i], vs[i], 1'b0, bc, dc, sd, r, c, o, z);
      nChecks++; if (!sd) begin nFails++; $display("FAIL dir%0d_done_seen got=0 want=1", i); end
      nChecks++; if (bc != NIB) begin nFails++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, NIB); end
      nChecks++; if (dc != NIB + 1) begin nFails++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, dc, NIB + 1); end
      nChecks++; if (r !== er) begin nFails++; $display("FAIL dir%0d_result got=%h want=%h", i, r, er); end
      nChecks++; if (c !== ec) begin nFails++; $display("FAIL dir%0d_cOut got=%b want=%b", i, c, ec); end
      nChecks++; if (o !== eo) begin nFails++; $display("FAIL dir%0d_ovf got=%b want=%b", i, o, eo); end
`ifdef ADDSUB_ZERO_FLAG_EN
      nChecks++; if (z !== (er == '0)) begin nFails++; $display("FAIL dir%0d_zero got=%b want=%b", i, z, (er == '0)); end
`endif
      @(negedge clk);
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, done); end
      nChecks++; if (result !== er) begin nFails++; $display("FAIL dir%0d_hold got=%h want=%h", i, result, er); end
    end
  endtask

  task automatic test_random();
    int bc, dc; bit sd;
    logic [W-1:0] ra, rb, r, er; logic rs, c, o, z, ec, eo;
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      runOp(ra, rb, rs, 1'b0, bc, dc, sd, r, c, o, z);
      nChecks++;
      if (!sd || r !== er || c !== ec || o !== eo)
      begin
        nFails++;
        $display("FAIL rand%0d a=%h b=%h sub=%b got=%h c=%b o=%b want=%h c=%b o=%b",
                 i, ra, rb, rs, r, c, o, er, ec, eo);
      end
`ifdef ADDSUB_ZERO_FLAG_EN
      nChecks++; if (z !== (er == '0)) begin nFails++; $display("FAIL rand%0d_zero got=%b want=%b", i, z, (er == '0)); end
`endif
    end
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] prev, er; logic ec, eo;
    prev = result;
    model(16'h4321, 16'h1111, 1'b1, er, ec, eo);
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; sub = 1'b1; start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      nChecks++; if (busy !== 1'b1) begin nFails++; $display("FAIL ign_busy_c%0d got=%b want=1", k, busy); end
      nChecks++; if (result !== prev) begin nFails++; $display("FAIL ign_hold_c%0d got=%h want=%h", k, result, prev); end
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    nChecks++; if (done !== 1'b1) begin nFails++; $display("FAIL ign_done got=%b want=1", done); end
    nChecks++; if (result !== er) begin nFails++; $display("FAIL ign_result got=%h want=%h", result, er); end
    nChecks++; if (cOut !== ec) begin nFails++; $display("FAIL ign_cOut got=%b want=%b", cOut, ec); end
    @(negedge clk);
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL ign_idle got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int bc, dc; bit sd;
    logic [W-1:0] r, er; logic c, o, z, ec, eo;
    model(16'h1234, 16'h0FFF, 1'b0, er, ec, eo);
    runOp(16'h1234, 16'h0FFF, 1'b0, 1'b0, bc, dc, sd, r, c, o, z);
    nChecks++; if (!sd || r !== er) begin nFails++; $display("FAIL b2b_first got=%h want=%h", r, er); end
    model(16'h0010, 16'h0001, 1'b1, er, ec, eo);
    runOp(16'h0010, 16'h0001, 1'b1, 1'b1, bc, dc, sd, r, c, o, z);
    nChecks++; if (!sd) begin nFails++; $display("FAIL b2b_done_seen got=0 want=1"); end
    nChecks++; if (dc != NIB + 1) begin nFails++; $display("FAIL b2b_latency got=%0d want=%0d", dc, NIB + 1); end
    nChecks++; if (r !== er) begin nFails++; $display("FAIL b2b_result got=%h want=%h", r, er); end
    nChecks++; if (c !== ec) begin nFails++; $display("FAIL b2b_cOut got=%b want=%b", c, ec); end
  endtask

  task automatic test_reset_midop();
    int bc, dc; bit sd;
    logic [W-1:0] r, er; logic c, o, z, ec, eo;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0) begin nFails++; $display("FAIL rmid_busy got=%b want=0", busy); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL rmid_done got=%b want=0", done); end
    nChecks++; if (result !== '0) begin nFails++; $display("FAIL rmid_result got=%h want=0", result); end
    nChecks++; if (cOut !== 1'b0 || ovf !== 1'b0) begin nFails++; $display("FAIL rmid_flags got=%b%b want=00", cOut, ovf); end
    @(negedge clk);
    rstN = 1'b1;
    repeat (NIB + 2) begin
      @(negedge clk);
      nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL rmid_nodone got=%b want=0", done); end
    end
    model(16'h000F, 16'h0000, 1'b0, er, ec, eo);
    runOp(16'h000F, 16'h0000, 1'b0, 1'b0, bc, dc, sd, r, c, o, z);
    nChecks++; if (!sd || r !== er) begin nFails++; $display("FAIL rmid_after got=%h want=%h", r, er); end
    nChecks++; if (c !== ec) begin nFails++; $display("FAIL rmid_after_cOut got=%b want=%b", c, ec); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
